// File: rtl/divisibility_pattern_gen.sv
// Stimulus source for the 4-bit divisibility indicator: walks Out through a mode-selected
// ascending sequence and presents the expected LED0/LED1 levels coherently with each value.
module divisibility_pattern_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       auto,
    input  logic       step,
    output logic [3:0] Out,
    output logic       exp_led0,
    output logic       exp_led1,
    output logic       busy,
    output logic       done
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [1:0]       seq_mode, seq_mode_next;
    logic [3:0]       value_next;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_next;
    logic             step_q;
    logic             advance;

    function automatic logic [3:0] first_of(input logic [1:0] m);
        case (m)
            2'b01:   return 4'd3;
            2'b10:   return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] last_of(input logic [1:0] m);
        case (m)
            2'b10:   return 4'd14;
            2'b11:   return 4'd13;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [3:0] succ_of(input logic [1:0] m, input logic [3:0] v);
        case (m)
            2'b00: return v + 4'd1;
            2'b01: return v + 4'd3;
            2'b10: return v + 4'd2;
            default: begin
                // mode 11 visits only the values where both flags are clear
                case (v)
                    4'd0:    return 4'd1;
                    4'd1:    return 4'd5;
                    4'd5:    return 4'd7;
                    4'd7:    return 4'd11;
                    default: return 4'd13;
                endcase
            end
        endcase
    endfunction

    function automatic logic flag_mult3(input logic [3:0] v);
        return v inside {4'd3, 4'd6, 4'd9, 4'd12, 4'd15};
    endfunction

    function automatic logic flag_even(input logic [3:0] v);
        return (v != 4'd0) && !v[0];
    endfunction

    always_comb begin
        state_next    = state;
        seq_mode_next = seq_mode;
        value_next    = Out;
        tick_cnt_next = tick_cnt;
        advance       = auto ? (tick_cnt == CNT_LAST) : (step && !step_q);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    seq_mode_next = mode;
                    value_next    = first_of(mode);
                    tick_cnt_next = '0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                tick_cnt_next = (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
                if (advance) begin
                    if (Out == last_of(seq_mode)) state_next = DONE;
                    else                          value_next = succ_of(seq_mode, Out);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            seq_mode <= '0;
            Out      <= '0;
            exp_led0 <= 1'b0;
            exp_led1 <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
            step_q   <= 1'b0;
        end else begin
            state    <= state_next;
            seq_mode <= seq_mode_next;
            Out      <= value_next;
            exp_led0 <= flag_mult3(value_next);
            exp_led1 <= flag_even(value_next);
            busy     <= (state_next == RUN);
            done     <= (state_next == DONE);
            tick_cnt <= tick_cnt_next;
            step_q   <= step;
        end
    end
endmodule

// File: doc/divisibility_pattern_gen.md
# divisibility_pattern_gen

Stimulus source for the 4-bit divisibility indicator: it steps a 4-bit value through a selected sequence and drives it onto the indicator's `In[3:0]` bus. Alongside each value it presents the expected LED0 and LED1 levels, so a board-level or bench comparator can check the indicator cycle by cycle. Values advance either on a manual step input (a debounced button) or on an internal timed tick.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per auto-advance tick. Legal values are ≥1; a value of 1 advances every cycle.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE or DONE, where it begins a sequence.
- `mode`  in  2  sequence select, captured on the accepted start.
- `auto`  in  1  advance source: 1 = internal tick, 0 = rising edge of `step`. Sampled live.
- `step`  in  1  manual advance, already debounced.
- `Out`  out  4  current pattern value; connects to the indicator `In`.
- `exp_led0`  out  1  expected LED0: `Out` is a nonzero multiple of 3.
- `exp_led1`  out  1  expected LED1: `Out` is nonzero and even.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- **Sequences**, ascending, selected by `mode`:
  - 00: 0..15 (16 values).
  - 01: 3, 6, 9, 12, 15.
  - 10: 2, 4, 6, 8, 10, 12, 14.
  - 11: 0, 1, 5, 7, 11, 13 (values where both flags are 0).
- **Expected flags**: `exp_led0` and `exp_led1` are registered and update in the same cycle as `Out`, so all three are always coherent.
  - Value 0 gives both flags 0.
  - Value 6 and value 12 give both flags 1.
- **FSM states**:
  - IDLE (reset state): outputs hold.
  - RUN.
  - DONE.
- **IDLE or DONE with `start`=1**: latch `mode`, load the first value of the sequence, clear the tick counter, and go to RUN.
- **RUN, advance event with `Out` not last**: load the next value of the sequence.
- **RUN, advance event with `Out` last**: go to DONE. `Out` and the flags hold the last value.
- **RUN**: `start` is ignored. A `mode` change mid-run has no effect until the next accepted start.
- **DONE**: `Out` holds until the next start. Start from DONE restarts exactly as from IDLE.
- **Advance event when `auto`=0**: `step`=1 and the registered `step_q`=0. `step_q` is updated every cycle in every state, so a `step` held high across a start does not produce an advance.
- **Advance event when `auto`=1**:
  - The tick counter runs 0..`TICK_DIV`-1 in RUN only.
  - The event fires when the counter equals `TICK_DIV`-1, and the counter wraps to 0.
  - Switching `auto` mid-run does not clear the counter.
- **Tick counter width**: `$clog2(TICK_DIV)`, minimum 1 bit. The counter never exceeds `TICK_DIV`-1.

## Timing
- **Reset values**: `Out`=0, `exp_led0`=0, `exp_led1`=0, `busy`=0, `done`=0, state IDLE, tick counter 0, `step_q`=0.
- **Reset mid-run**: returns to IDLE on the next edge with all of the above values, regardless of state. Reset has priority over start and advance.
- **Start latency**: start sampled at edge N; at edge N+1 `Out` holds the first value and `busy`=1.
- **Step latency**: `step` rises at edge N (sampled high while `step_q` is low); `Out` takes the next value at edge N+1. One advance per rising edge of `step`, however long it is held.
- **Auto spacing**: in auto mode the first advance occurs `TICK_DIV` cycles after entry to RUN, and subsequent advances every `TICK_DIV` cycles.
- **Completion**: the advance event on the last value sets `done`=1 and `busy`=0 at the next edge. `Out` is unchanged at that edge.
- **Outputs**: all outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset and first start**: assert `rst` for 2 cycles, then `start` for 1 cycle with `mode`=01, `auto`=0. Required: `Out`=0 with flags 0/0 during reset; `Out`=3, `exp_led0`=1, `exp_led1`=0, `busy`=1 one cycle after start.
- **Manual walk, mode 10**: pulse `step` 7 times, each pulse 3 cycles wide. Required: `Out` steps 2, 4, 6, 8, 10, 12, 14; `exp_led0`=1 only at 6 and 12; `exp_led1`=1 throughout; the 7th pulse sets `done`=1 with `Out`=14. A `step` held 10 cycles advances exactly once.
- **Auto walk**: `TICK_DIV`=4, `mode`=00, `auto`=1. Required: `Out` increments every 4 cycles from 0 to 15; `done` asserts 4 cycles after `Out` reaches 15; flag pairs match the nonzero-multiple-of-3 and nonzero-even rules for all 16 values.
- **Ignored inputs in RUN**: in RUN with `mode`=11, pulse `start` and change `mode` to 00. Required: the sequence continues 0, 1, 5, 7, 11, 13 with both flags 0; no restart occurs.
- **Reset mid-run**: assert `rst` while `Out`=9 in mode 01. Required: the next edge gives `Out`=0, `busy`=0, `done`=0; a following start in mode 01 yields `Out`=3.
- **Restart from DONE and `TICK_DIV` of 1**: start from DONE with `TICK_DIV`=1, `mode`=01, `auto`=1. Required: `Out` = 3, 6, 9, 12, 15 on consecutive cycles, then `done`=1.
